// File: rtl/tia_hcounter.sv
// tia_hcounter: horizontal timing generator for the TIA core.
// Divides the colour clock by four into phi1/phi2, steps a 6-bit LFSR
// through 57 states per 228-clock line, and decodes blank/sync/burst/
// centre/end-of-line flags from that count.
// Optional feature macro: TIA_HMOVE_EXTEND_EN (late-hblank extension on hmove).
module tia_hcounter (
   input  logic       clk,
   input  logic       reset,
   input  logic       rsync,
   input  logic       hmove,
   output logic       phi1,
   output logic       phi2,
   output logic [5:0] hpoly,
   output logic       hblank,
   output logic       hsync,
   output logic       cburst,
   output logic       center,
   output logic       line_end
);

   // LFSR state reached after a given number of steps from 000000; used
   // only at elaboration to turn count indices into state constants.
   function automatic logic [5:0] lfsr_at(input int steps);
      logic [5:0] v;
      v = 6'd0;
      for (int i = 0; i < steps; i++) begin
         v = {v[4:0], ~(v[5] ^ v[4])};
      end
      return v;
   endfunction

   localparam logic [5:0] K_WRAP      = lfsr_at(56);
   localparam logic [5:0] K_HSYNC_ON  = lfsr_at(4);
   localparam logic [5:0] K_BURST_ON  = lfsr_at(8);
   localparam logic [5:0] K_BURST_OFF = lfsr_at(12);
   localparam logic [5:0] K_HBLANK_RL = lfsr_at(16);
   localparam logic [5:0] K_CENTER    = lfsr_at(36);
`ifdef TIA_HMOVE_EXTEND_EN
   localparam logic [5:0] K_HBLANK_XT = lfsr_at(18);
`endif

   logic [1:0] p;
   logic [5:0] s;
   logic [5:0] s_next;
   logic       advance;

`ifdef TIA_HMOVE_EXTEND_EN
   logic ext_latch;
   logic early;
`else
   logic unused_hmove;
   assign unused_hmove = hmove;
`endif

   assign phi1  = (p == 2'd1);
   assign phi2  = (p == 2'd3);
   assign hpoly = s;

   // Next LFSR value: shift normally, but fold the last count and the
   // all-ones lockup state back to 000000 so the line is exactly 57 counts.
   always_comb begin
      advance = (p == 2'd3);
      s_next  = {s[4:0], ~(s[5] ^ s[4])};
      if (s == K_WRAP || s == 6'h3F) begin
         s_next = 6'd0;
      end
   end

   // Phase counter, LFSR and the decoded line flags; flags are evaluated
   // from the new count so they change on the same edge as hpoly.
   always_ff @(posedge clk) begin
      if (reset || rsync) begin
         p        <= 2'd0;
         s        <= 6'd0;
         hblank   <= 1'b1;
         hsync    <= 1'b0;
         cburst   <= 1'b0;
         center   <= 1'b0;
         line_end <= 1'b0;
      end else begin
         p        <= p + 2'd1;
         center   <= 1'b0;
         line_end <= 1'b0;
         if (advance) begin
            s <= s_next;
            if (s_next == 6'd0) begin
               hblank   <= 1'b1;
               line_end <= 1'b1;
            end
            if (s_next == K_HSYNC_ON) begin
               hsync <= 1'b1;
            end
            if (s_next == K_BURST_ON) begin
               hsync  <= 1'b0;
               cburst <= 1'b1;
            end
            if (s_next == K_BURST_OFF) begin
               cburst <= 1'b0;
            end
            if (s_next == K_HBLANK_RL) begin
`ifdef TIA_HMOVE_EXTEND_EN
               if (!ext_latch) begin
                  hblank <= 1'b0;
               end
`else
               hblank <= 1'b0;
`endif
            end
`ifdef TIA_HMOVE_EXTEND_EN
            if (s_next == K_HBLANK_XT && ext_latch) begin
               hblank <= 1'b0;
            end
`endif
            if (s_next == K_CENTER) begin
               center <= 1'b1;
            end
         end
      end
   end

`ifdef TIA_HMOVE_EXTEND_EN
   // Extension latch: armed by hmove during the early-blank window (k<16,
   // tracked by 'early'), consumed when the late release point is reached.
   always_ff @(posedge clk) begin
      if (reset || rsync) begin
         ext_latch <= 1'b0;
         early     <= 1'b1;
      end else begin
         if (hmove && hblank && early) begin
            ext_latch <= 1'b1;
         end
         if (advance) begin
            if (s_next == 6'd0) begin
               early <= 1'b1;
            end
            if (s_next == K_HBLANK_RL) begin
               early <= 1'b0;
            end
            if (s_next == K_HBLANK_XT) begin
               ext_latch <= 1'b0;
            end
         end
      end
   end
`endif

endmodule
